// File: rtl/rstmgr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rstmgr_pkg
// Description : Shared types and constants for the sequenced reset manager:
//               FSM state enum and reset-cause bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package rstmgr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int CAUSE_W    = 4;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_PROG = 1;
  localparam int CAUSE_NDM  = 2;
  localparam int CAUSE_SW   = 3;

endpackage
`default_nettype wire

// File: rtl/rstmgr_sync.sv
`default_nettype none
// ============================================================================
// Module      : rstmgr_sync
// Description : Parametrised-depth flop synchroniser for an asynchronous
//               level, with a selectable value loaded during reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rstmgr_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rstmgr_seq.sv
`default_nettype none
// ============================================================================
// Module      : rstmgr_seq
// Description : Sequenced reset manager. Collects POR, programmer, ndmreset
//               and software requests, stretches the affected domain resets
//               and releases them one by one in ascending order with a gap.
//               Records a sticky reset cause.
// Revision    : 1.0 - initial release
// ============================================================================
module rstmgr_seq
  import rstmgr_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   prog_rst_ni,
  input  logic                   ndmreset_i,
  input  logic [NUM_DOMAINS-1:0] ndm_mask_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  input  logic                   cause_clr_i,
  output logic [NUM_DOMAINS-1:0] rst_no,
  output logic                   busy_o,
  output logic [CAUSE_W-1:0]     cause_o
);

  localparam int c_max_cyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);
  localparam int c_idx_w   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [CAUSE_W-1:0] c_cause_por = CAUSE_W'(1 << CAUSE_POR);

  state_e               r_state;
  logic [NUM_DOMAINS-1:0] r_active;
  logic [NUM_DOMAINS-1:0] r_pending;
  logic [CAUSE_W-1:0]   r_pend_cause;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic                 r_busy;
  logic [CAUSE_W-1:0]   r_cause;

  logic                 w_prog_s;
  logic                 w_ndm_s;
  logic [NUM_DOMAINS-1:0] w_req;
  logic [NUM_DOMAINS-1:0] w_start;
  logic [CAUSE_W-1:0]   w_req_cause;
  logic [CAUSE_W-1:0]   w_cause_set;
  logic [c_idx_w-1:0]   w_first_idx;
  logic [c_idx_w-1:0]   w_next_idx;
  logic                 w_first_more;
  logic                 w_next_more;

  // The programmer request is active-low at the pin; invert before syncing.
  rstmgr_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_prog (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (~prog_rst_ni),
    .o_q   (w_prog_s)
  );

  rstmgr_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_ndm (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (ndmreset_i),
    .o_q   (w_ndm_s)
  );

  // Per-cycle request vector and the cause types that actually hit a domain.
  always_comb begin
    w_req = sw_rst_req_i;
    if (w_prog_s) w_req = {NUM_DOMAINS{1'b1}};
    if (w_ndm_s)  w_req = w_req | ndm_mask_i;
    w_start = r_pending | w_req;
    w_req_cause             = '0;
    w_req_cause[CAUSE_PROG] = w_prog_s;
    w_req_cause[CAUSE_NDM]  = w_ndm_s & (|ndm_mask_i);
    w_req_cause[CAUSE_SW]   = |sw_rst_req_i;
  end

  // Locate the lowest active domain and the next active one above r_idx,
  // plus whether anything active remains above each of them.
  always_comb begin
    w_first_idx  = '0;
    w_next_idx   = '0;
    w_first_more = 1'b0;
    w_next_more  = 1'b0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (r_active[i]) w_first_idx = c_idx_w'(i);
      if (r_active[i] && (i > int'(r_idx))) w_next_idx = c_idx_w'(i);
    end
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (r_active[i] && (i > int'(w_first_idx))) w_first_more = 1'b1;
      if (r_active[i] && (i > int'(w_next_idx)))  w_next_more  = 1'b1;
    end
  end

  // Cause bits raised this cycle: on acceptance from IDLE or merge in HOLD.
  always_comb begin
    w_cause_set = '0;
    case (r_state)
      IDLE:    if (w_start != '0) w_cause_set = r_pend_cause | w_req_cause;
      HOLD:    w_cause_set = w_req_cause;
      default: w_cause_set = '0;
    endcase
  end

  // Sequencer: stretch active domains in HOLD, then release them one by one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= HOLD;
      r_active     <= {NUM_DOMAINS{1'b1}};
      r_pending    <= '0;
      r_pend_cause <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_rst_n      <= '0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start != '0) begin
            r_state      <= HOLD;
            r_active     <= w_start;
            r_rst_n      <= r_rst_n & ~w_start;
            r_cnt        <= '0;
            r_pending    <= '0;
            r_pend_cause <= '0;
            r_busy       <= 1'b1;
          end
        end
        HOLD: begin
          r_pending    <= '0;
          r_pend_cause <= '0;
          if (w_req != '0) begin
            // A new or still-active request restarts the stretch.
            r_active <= r_active | w_req;
            r_rst_n  <= r_rst_n & ~w_req;
            r_cnt    <= '0;
          end else if (r_cnt == c_hold_last) begin
            r_rst_n[w_first_idx] <= 1'b1;
            r_idx                <= w_first_idx;
            r_cnt                <= '0;
            if (w_first_more) begin
              r_state <= RELEASE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        RELEASE: begin
          // Late requests are parked and start a fresh sequence from IDLE.
          r_pending    <= r_pending | w_req;
          r_pend_cause <= r_pend_cause | w_req_cause;
          if (r_cnt == c_gap_last) begin
            r_rst_n[w_next_idx] <= 1'b1;
            r_idx               <= w_next_idx;
            r_cnt               <= '0;
            if (!w_next_more) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky cause flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cause <= c_cause_por;
    end else begin
      r_cause <= (cause_clr_i ? '0 : r_cause) | w_cause_set;
    end
  end

  assign rst_no  = r_rst_n;
  assign busy_o  = r_busy;
  assign cause_o = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_rstmgr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rstmgr_seq
// Description : Self-checking bench for rstmgr_seq. A timeline reference
//               model predicts every domain release from the last
//               acceptance/merge edge; scenario tasks add targeted checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rstmgr_seq;

  localparam int N = 4;
  localparam int H = 16;
  localparam int G = 4;
  localparam int S = 2;

  logic         clk        = 1'b0;
  logic         rst        = 1'b0;
  logic         prog_rst_n = 1'b1;
  logic         ndmreset   = 1'b0;
  logic [N-1:0] ndm_mask   = '0;
  logic [N-1:0] sw_req     = '0;
  logic         cause_clr  = 1'b0;
  logic [N-1:0] rst_n;
  logic         busy;
  logic [3:0]   cause;

  int n_cmp = 0;
  int n_bad = 0;

  rstmgr_seq #(
    .NUM_DOMAINS (N),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .SYNC_STAGES (S)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .prog_rst_ni  (prog_rst_n),
    .ndmreset_i   (ndmreset),
    .ndm_mask_i   (ndm_mask),
    .sw_rst_req_i (sw_req),
    .cause_clr_i  (cause_clr),
    .rst_no       (rst_n),
    .busy_o       (busy),
    .cause_o      (cause)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A sequence is described by its active set and an anchor edge; the k-th
  // active domain is due at anchor + H + k*G. Async inputs reach the model
  // through an S-deep history queue.
  int           m_edge       = 0;
  logic [N-1:0] m_rst_n      = '0;
  logic [N-1:0] m_active     = '1;
  logic [N-1:0] m_pend       = '0;
  logic [3:0]   m_pend_types = '0;
  logic         m_busy       = 1'b1;
  logic [3:0]   m_cause      = 4'b0001;
  bit           m_in_seq     = 1'b1;
  int           m_anchor     = 0;
  int           m_nrel       = 0;
  bit           m_prog_q[$];
  bit           m_ndm_q[$];
  bit           m_ps, m_ns;
  int           m_k;
  logic [N-1:0] m_req;
  logic [3:0]   m_types, m_set;

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      m_rst_n      = '0;
      m_busy       = 1'b1;
      m_cause      = 4'b0001;
      m_active     = '1;
      m_pend       = '0;
      m_pend_types = '0;
      m_in_seq     = 1'b1;
      m_anchor     = m_edge;
      m_nrel       = 0;
      m_prog_q.delete();
      m_ndm_q.delete();
      for (int i = 0; i < S; i++) begin
        m_prog_q.push_back(1'b0);
        m_ndm_q.push_back(1'b0);
      end
    end else begin
      m_ps = m_prog_q.pop_front();
      m_ns = m_ndm_q.pop_front();
      m_prog_q.push_back(!prog_rst_n);
      m_ndm_q.push_back(ndmreset);
      m_req   = sw_req | (m_ps ? {N{1'b1}} : '0) | (m_ns ? ndm_mask : '0);
      m_types = {(|sw_req), (m_ns && (|ndm_mask)), m_ps, 1'b0};
      m_set   = '0;
      if (!m_in_seq) begin
        if ((m_pend | m_req) != '0) begin
          m_active     = m_pend | m_req;
          m_rst_n      = m_rst_n & ~m_active;
          m_anchor     = m_edge;
          m_in_seq     = 1'b1;
          m_nrel       = 0;
          m_set        = m_pend_types | m_types;
          m_pend       = '0;
          m_pend_types = '0;
        end
      end else if (m_nrel == 0 && m_req != '0) begin
        m_active = m_active | m_req;
        m_rst_n  = m_rst_n & ~m_req;
        m_anchor = m_edge;
        m_set    = m_types;
      end else begin
        m_k = 0;
        for (int d = 0; d < N; d++) begin
          if (m_active[d]) begin
            if (m_anchor + H + m_k * G == m_edge) begin
              m_rst_n[d] = 1'b1;
              m_nrel++;
            end
            m_k++;
          end
        end
        if (m_nrel == $countones(m_active)) m_in_seq = 1'b0;
        m_pend       = m_pend | m_req;
        m_pend_types = m_pend_types | m_types;
      end
      m_cause = (cause_clr ? 4'b0000 : m_cause) | m_set;
      m_busy  = m_in_seq;
    end
  end

  // ---------------- helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int j = 0; j < 300 && busy !== 1'b0; j++) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_idle: busy got %b want 0 after 300 cycles", busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int rise[N];
    int fall;
    for (int d = 0; d < N; d++) rise[d] = -1;
    fall = -1;
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (rst_n !== 4'b0000) begin n_bad++; $display("FAIL reset rst_no: got %b want 0000", rst_n); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL reset busy: got %b want 1", busy); end
    n_cmp++;
    if (cause !== 4'b0001) begin n_bad++; $display("FAIL reset cause: got %b want 0001", cause); end
    rst = 1'b0;
    for (int j = 1; j <= 34; j++) begin
      tick();
      n_cmp++;
      if (rst_n !== m_rst_n) begin n_bad++; $display("FAIL por rst_no: got %b want %b t=%0t", rst_n, m_rst_n, $time); end
      n_cmp++;
      if (busy !== m_busy) begin n_bad++; $display("FAIL por busy: got %b want %b t=%0t", busy, m_busy, $time); end
      n_cmp++;
      if (cause !== m_cause) begin n_bad++; $display("FAIL por cause: got %b want %b t=%0t", cause, m_cause, $time); end
      for (int d = 0; d < N; d++) if (rst_n[d] === 1'b1 && rise[d] < 0) rise[d] = j;
      if (busy === 1'b0 && fall < 0) fall = j;
    end
    for (int d = 0; d < N; d++) begin
      n_cmp++;
      if (rise[d] != H + d * G) begin
        n_bad++;
        $display("FAIL por release edge dom%0d: got %0d want %0d", d, rise[d], H + d * G);
      end
    end
    n_cmp++;
    if (fall != H + (N - 1) * G) begin n_bad++; $display("FAIL por busy fall: got %0d want %0d", fall, H + (N - 1) * G); end
  endtask

  task automatic test_sw();
    int low_cnt;
    low_cnt = 0;
    wait_idle();
    for (int j = 0; j < 30; j++) begin
      sw_req = (j == 0) ? 4'b0100 : 4'b0000;
      tick();
      sw_req = '0;
      if (rst_n[2] === 1'b0) low_cnt++;
      n_cmp++;
      if (rst_n !== m_rst_n) begin n_bad++; $display("FAIL sw rst_no: got %b want %b t=%0t", rst_n, m_rst_n, $time); end
      n_cmp++;
      if (busy !== m_busy) begin n_bad++; $display("FAIL sw busy: got %b want %b t=%0t", busy, m_busy, $time); end
      n_cmp++;
      if (cause !== m_cause) begin n_bad++; $display("FAIL sw cause: got %b want %b t=%0t", cause, m_cause, $time); end
    end
    n_cmp++;
    if (low_cnt != H) begin n_bad++; $display("FAIL sw low cycles: got %0d want %0d", low_cnt, H); end
    n_cmp++;
    if (cause[3] !== 1'b1) begin n_bad++; $display("FAIL sw cause bit3: got %b want 1", cause[3]); end
  endtask

  task automatic test_ndm();
    int  first_low;
    bit  d0_touched;
    first_low  = -1;
    d0_touched = 1'b0;
    wait_idle();
    ndm_mask = 4'b1110;
    ndmreset = 1'b1;
    for (int j = 1; j <= 80; j++) begin
      tick();
      if (j == 40) ndmreset = 1'b0;
      if (rst_n[1] === 1'b0 && first_low < 0) first_low = j;
      if (rst_n[0] !== 1'b1) d0_touched = 1'b1;
      n_cmp++;
      if (rst_n !== m_rst_n) begin n_bad++; $display("FAIL ndm rst_no: got %b want %b t=%0t", rst_n, m_rst_n, $time); end
      n_cmp++;
      if (busy !== m_busy) begin n_bad++; $display("FAIL ndm busy: got %b want %b t=%0t", busy, m_busy, $time); end
      n_cmp++;
      if (cause !== m_cause) begin n_bad++; $display("FAIL ndm cause: got %b want %b t=%0t", cause, m_cause, $time); end
    end
    n_cmp++;
    if (first_low != S + 1) begin n_bad++; $display("FAIL ndm assert latency: got %0d want %0d", first_low, S + 1); end
    n_cmp++;
    if (d0_touched) begin n_bad++; $display("FAIL ndm masked dom0: got touched want untouched"); end
    n_cmp++;
    if (cause[2] !== 1'b1) begin n_bad++; $display("FAIL ndm cause bit2: got %b want 1", cause[2]); end
    ndm_mask = '0;
  endtask

  task automatic test_prog_release();
    bit fell, rose;
    int dips;
    fell = 1'b0; rose = 1'b0; dips = 0;
    wait_idle();
    sw_req = 4'b1111;
    tick();
    sw_req = '0;
    for (int j = 0; j < 100 && rst_n[1] !== 1'b1; j++) tick();
    n_cmp++;
    if (rst_n[1] !== 1'b1) begin n_bad++; $display("FAIL prog wait dom1 release: got %b want 1", rst_n[1]); end
    for (int j = 0; j < 60; j++) begin
      prog_rst_n = (j < 5) ? 1'b0 : 1'b1;
      tick();
      if (busy === 1'b0 && !fell) begin fell = 1'b1; dips = 1; end
      else if (fell && !rose && busy === 1'b0) dips++;
      else if (fell && busy === 1'b1) rose = 1'b1;
      n_cmp++;
      if (rst_n !== m_rst_n) begin n_bad++; $display("FAIL prog rst_no: got %b want %b t=%0t", rst_n, m_rst_n, $time); end
      n_cmp++;
      if (busy !== m_busy) begin n_bad++; $display("FAIL prog busy: got %b want %b t=%0t", busy, m_busy, $time); end
      n_cmp++;
      if (cause !== m_cause) begin n_bad++; $display("FAIL prog cause: got %b want %b t=%0t", cause, m_cause, $time); end
    end
    prog_rst_n = 1'b1;
    n_cmp++;
    if (!(rose && dips == 1)) begin n_bad++; $display("FAIL prog busy dip: got %0d cycles (rose=%0d) want 1", dips, rose); end
    n_cmp++;
    if (cause[1] !== 1'b1) begin n_bad++; $display("FAIL prog cause bit1: got %b want 1", cause[1]); end
  endtask

  task automatic test_merge();
    int rise0, rise3;
    rise0 = -1; rise3 = -1;
    wait_idle();
    for (int j = -5; j <= 30; j++) begin
      sw_req = (j == -5) ? 4'b0001 : (j == 0) ? 4'b1000 : 4'b0000;
      tick();
      sw_req = '0;
      if (j >= 1 && rst_n[0] === 1'b1 && rise0 < 0) rise0 = j;
      if (j >= 1 && rst_n[3] === 1'b1 && rise3 < 0) rise3 = j;
      n_cmp++;
      if (rst_n !== m_rst_n) begin n_bad++; $display("FAIL merge rst_no: got %b want %b t=%0t", rst_n, m_rst_n, $time); end
      n_cmp++;
      if (busy !== m_busy) begin n_bad++; $display("FAIL merge busy: got %b want %b t=%0t", busy, m_busy, $time); end
    end
    n_cmp++;
    if (rise0 != H) begin n_bad++; $display("FAIL merge dom0 release: got %0d want %0d", rise0, H); end
    n_cmp++;
    if (rise3 != H + G) begin n_bad++; $display("FAIL merge dom3 release: got %0d want %0d", rise3, H + G); end
  endtask

  task automatic test_abort();
    wait_idle();
    sw_req = 4'b1111;
    tick();
    sw_req = '0;
    for (int j = 0; j < 100 && rst_n[0] !== 1'b1; j++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rst_n !== 4'b0000) begin n_bad++; $display("FAIL abort rst_no: got %b want 0000", rst_n); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL abort busy: got %b want 1", busy); end
    n_cmp++;
    if (cause !== 4'b0001) begin n_bad++; $display("FAIL abort cause: got %b want 0001", cause); end
    tick();
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tick();
      n_cmp++;
      if (rst_n !== m_rst_n) begin n_bad++; $display("FAIL abort rst_no seq: got %b want %b t=%0t", rst_n, m_rst_n, $time); end
      n_cmp++;
      if (busy !== m_busy) begin n_bad++; $display("FAIL abort busy seq: got %b want %b t=%0t", busy, m_busy, $time); end
    end
  endtask

  task automatic test_clear();
    wait_idle();
    cause_clr = 1'b1;
    sw_req    = 4'b1000;
    tick();
    cause_clr = 1'b0;
    sw_req    = '0;
    n_cmp++;
    if (cause !== 4'b1000) begin n_bad++; $display("FAIL clear cause: got %b want 1000", cause); end
    n_cmp++;
    if (cause !== m_cause) begin n_bad++; $display("FAIL clear cause model: got %b want %b", cause, m_cause); end
  endtask

  task automatic test_random();
    int ndm_left, prog_left, rst_left;
    ndm_left = 0; prog_left = 0; rst_left = 0;
    wait_idle();
    ndm_mask = 4'($urandom_range(0, 15));
    for (int j = 0; j < 600; j++) begin
      sw_req    = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cause_clr = ($urandom_range(0, 29) == 0);
      if (ndm_left == 0 && $urandom_range(0, 79) == 0) ndm_left = $urandom_range(1, 12);
      if (prog_left == 0 && $urandom_range(0, 99) == 0) prog_left = $urandom_range(1, 6);
      if (rst_left == 0 && $urandom_range(0, 249) == 0) rst_left = $urandom_range(1, 2);
      ndmreset   = (ndm_left > 0);
      prog_rst_n = !(prog_left > 0);
      rst        = (rst_left > 0);
      if (ndm_left > 0) ndm_left--;
      if (prog_left > 0) prog_left--;
      if (rst_left > 0) rst_left--;
      tick();
      n_cmp++;
      if (rst_n !== m_rst_n) begin n_bad++; $display("FAIL rand rst_no: got %b want %b t=%0t", rst_n, m_rst_n, $time); end
      n_cmp++;
      if (busy !== m_busy) begin n_bad++; $display("FAIL rand busy: got %b want %b t=%0t", busy, m_busy, $time); end
      n_cmp++;
      if (cause !== m_cause) begin n_bad++; $display("FAIL rand cause: got %b want %b t=%0t", cause, m_cause, $time); end
    end
    sw_req = '0; cause_clr = 1'b0; ndmreset = 1'b0; prog_rst_n = 1'b1; rst = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_sw();
    test_ndm();
    test_prog_release();
    test_merge();
    test_abort();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
